// File: rtl/jt900h_memresp_if.sv
// rtl/jt900h_memresp_if.sv - jt900h CPU bus as seen by the memory responder
interface jt900h_memresp_if;
  logic [23:1] cpu_addr;
  logic [15:0] cpu_dout;
  logic [1:0]  cpu_we;
  logic [15:0] cpu_din;
  logic        cpu_busy;

  modport master (output cpu_addr, cpu_dout, cpu_we, input cpu_din, cpu_busy);
  modport slave  (input cpu_addr, cpu_dout, cpu_we, output cpu_din, cpu_busy);
endinterface

// File: rtl/jt900h_memresp.sv
// rtl/jt900h_memresp.sv - jt900h CPU bus responder: internal RAM, ROM handshake and IO port
module jt900h_memresp #(
  parameter int         RAMW     = 12,
  parameter logic [9:0] RAM_PAGE = 10'h001,
  parameter int         IO_WS    = 2
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  jt900h_memresp_if.slave cpu,
  output logic            rom_cs,
  output logic [21:0]     rom_addr,
  input  logic [15:0]     rom_data,
  input  logic            rom_ok,
  output logic            io_cs,
  output logic [6:0]      io_addr,
  output logic [15:0]     io_dout,
  output logic [1:0]      io_we,
  input  logic [15:0]     io_din
);
  localparam logic [3:0] WS = 4'(IO_WS);

  typedef enum logic [1:0] {ST_IDLE, ST_RAM, ST_ROM, ST_IO} state_t;
  typedef enum logic [1:0] {RG_OPEN, RG_RAM, RG_ROM, RG_IO} region_t;

  state_t          st;
  region_t         region;
  logic [23:1]     last_addr;
  logic [1:0]      last_we;
  logic            last_valid;
  logic [23:1]     req_addr;
  logic [1:0]      req_we;
  logic [15:0]     req_dout;
  logic [3:0]      io_cnt;
  logic            rom_cs_d;
  logic            start;
  logic [15:0]     ram [2**RAMW];
  logic [RAMW-1:0] ram_idx;
  logic [15:0]     ram_rd;
  logic [15:0]     ram_new;
  logic            ram_wr;

  // Address decode; ROM wins over a RAM page that would overlap it
  always_comb begin
    region = RG_OPEN;
    if (cpu.cpu_addr[23])
      region = RG_ROM;
    else if (cpu.cpu_addr[23:14] == RAM_PAGE)
      region = RG_RAM;
    else if (cpu.cpu_addr[23:8] == 16'd0)
      region = RG_IO;
  end

  // An access starts only for a request that differs from the last one served
  assign start = cen && (st == ST_IDLE) &&
                 (!last_valid || ({cpu.cpu_addr, cpu.cpu_we} != {last_addr, last_we}));

  assign cpu.cpu_busy = !rst && ((start && (region != RG_OPEN)) || (st != ST_IDLE));

  // RAM word after the byte merge; this is both the write-back and the read data
  assign ram_idx = req_addr[RAMW:1];
  assign ram_rd  = ram[ram_idx];
  assign ram_new = {req_we[1] ? req_dout[15:8] : ram_rd[15:8],
                    req_we[0] ? req_dout[7:0]  : ram_rd[7:0]};
  assign ram_wr  = cen && (st == ST_RAM) && (req_we != 2'b00);

  // RAM array write-back on the single RAM cycle
  always_ff @(posedge clk) begin
    if (ram_wr)
      ram[ram_idx] <= ram_new;
  end

  // rom_cs history on raw clk, so an rom_ok already high when rom_cs rises is not taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rom_cs_d <= 1'b0;
    else
      rom_cs_d <= rom_cs;
  end

  // Access FSM: latches the request, runs the region handshake, records the served request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_IDLE;
      last_valid  <= 1'b0;
      last_addr   <= '0;
      last_we     <= 2'b00;
      req_addr    <= '0;
      req_we      <= 2'b00;
      req_dout    <= 16'd0;
      io_cnt      <= 4'd0;
      cpu.cpu_din <= 16'd0;
      rom_cs      <= 1'b0;
      rom_addr    <= 22'd0;
      io_cs       <= 1'b0;
      io_addr     <= 7'd0;
      io_dout     <= 16'd0;
      io_we       <= 2'b00;
    end else if (cen) begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            req_addr <= cpu.cpu_addr;
            req_we   <= cpu.cpu_we;
            req_dout <= cpu.cpu_dout;
            case (region)
              RG_RAM: st <= ST_RAM;
              RG_ROM: begin
                if (cpu.cpu_we == 2'b00) begin
                  st       <= ST_ROM;
                  rom_cs   <= 1'b1;
                  rom_addr <= cpu.cpu_addr[22:1];
                end else begin
                  // ROM writes are dropped with no wait
                  last_valid <= 1'b1;
                  last_addr  <= cpu.cpu_addr;
                  last_we    <= cpu.cpu_we;
                end
              end
              RG_IO: begin
                st      <= ST_IO;
                io_cs   <= 1'b1;
                io_addr <= cpu.cpu_addr[7:1];
                io_dout <= cpu.cpu_dout;
                io_cnt  <= WS;
                io_we   <= (WS == 4'd0) ? cpu.cpu_we : 2'b00;
              end
              default: begin
                // open bus: reads float high, writes vanish
                if (cpu.cpu_we == 2'b00)
                  cpu.cpu_din <= 16'hFFFF;
                last_valid <= 1'b1;
                last_addr  <= cpu.cpu_addr;
                last_we    <= cpu.cpu_we;
              end
            endcase
          end
        end
        ST_RAM: begin
          if (req_we == 2'b00)
            cpu.cpu_din <= ram_new;
          last_valid <= 1'b1;
          last_addr  <= req_addr;
          last_we    <= req_we;
          st         <= ST_IDLE;
        end
        ST_ROM: begin
          if (rom_ok && rom_cs_d) begin
            cpu.cpu_din <= rom_data;
            rom_cs      <= 1'b0;
            last_valid  <= 1'b1;
            last_addr   <= req_addr;
            last_we     <= req_we;
            st          <= ST_IDLE;
          end
        end
        default: begin
          if (io_cnt == 4'd0) begin
            if (req_we == 2'b00)
              cpu.cpu_din <= io_din;
            io_cs      <= 1'b0;
            io_we      <= 2'b00;
            last_valid <= 1'b1;
            last_addr  <= req_addr;
            last_we    <= req_we;
            st         <= ST_IDLE;
          end else begin
            io_cnt <= io_cnt - 4'd1;
            if (io_cnt == 4'd1)
              io_we <= req_we;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jt900h_memresp.sv
// tb/tb_jt900h_memresp.sv - randomized bench for jt900h_memresp with a transaction-level model
module tb_jt900h_memresp;
  localparam int RAMW  = 12;
  localparam int IO_WS = 2;
  localparam int R_OPEN = 0, R_RAM = 1, R_ROM = 2, R_IO = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        rom_cs;
  logic [21:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_ok;
  logic        io_cs;
  logic [6:0]  io_addr;
  logic [15:0] io_dout;
  logic [1:0]  io_we;
  logic [15:0] io_din;

  jt900h_memresp_if cpu();

  jt900h_memresp #(.RAMW(RAMW), .RAM_PAGE(10'h001), .IO_WS(IO_WS)) dut (
    .rst(rst), .clk(clk), .cen(cen), .cpu(cpu),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .io_cs(io_cs), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_din(io_din)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: 8 RAM words in use, last served request, CPU read register
  logic [15:0] m_ram [8];
  logic        m_last_valid = 1'b0;
  logic [23:1] m_last_addr = '0;
  logic [1:0]  m_last_we = 2'b00;
  logic [15:0] m_din = 16'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int region_of(input logic [23:0] b);
    if (b[23]) return R_ROM;
    if (b[23:14] == 10'h001) return R_RAM;
    if (b[23:8] == 16'd0) return R_IO;
    return R_OPEN;
  endfunction

  task automatic model_apply(input int rg, input logic [23:0] b, input logic [1:0] we,
                             input logic [15:0] dout, input logic [15:0] rom_val,
                             input logic [15:0] io_val);
    logic [2:0] idx;
    idx = b[3:1];
    m_last_valid = 1'b1;
    m_last_addr  = b[23:1];
    m_last_we    = we;
    if (rg == R_OPEN && we == 2'b00) m_din = 16'hFFFF;
    if (rg == R_RAM) begin
      if (we[0]) m_ram[idx][7:0]  = dout[7:0];
      if (we[1]) m_ram[idx][15:8] = dout[15:8];
      if (we == 2'b00) m_din = m_ram[idx];
    end
    if (rg == R_ROM && we == 2'b00) m_din = rom_val;
    if (rg == R_IO && we == 2'b00) m_din = io_val;
  endtask

  // Present one request, play ROM/IO responders, predict per-clk busy/cs/we timelines and check
  task automatic do_access(input logic [23:0] b, input logic [1:0] we, input logic [15:0] dout,
                           input int lat, input bit fast, input string tag);
    int          rg;
    bit          is_new, rom_rd, zero_wait, cv, okv;
    int          phase, start_c, cnt, tail, comp;
    logic [63:0] eb, ob, erc, orc, eic, oic, eiw, oiw;
    logic [15:0] rom_val, io_val;
    logic [1:0]  iowe_at_comp;
    rg        = region_of(b);
    is_new    = !m_last_valid || (b[23:1] != m_last_addr) || (we != m_last_we);
    rom_rd    = (rg == R_ROM) && (we == 2'b00);
    zero_wait = (rg == R_OPEN) || ((rg == R_ROM) && (we != 2'b00));
    phase = 0; start_c = -1; cnt = 0; tail = 0; comp = -1;
    eb = '0; ob = '0; erc = '0; orc = '0; eic = '0; oic = '0; eiw = '0; oiw = '0;
    iowe_at_comp = 2'b00;
    rom_val = 16'($urandom);
    io_val  = 16'($urandom);
    cpu.cpu_addr = b[23:1];
    cpu.cpu_we   = we;
    cpu.cpu_dout = dout;
    rom_data     = rom_val;
    io_din       = io_val;
    for (int c = 0; c < 64 && !(phase == 2 && tail >= 2); c++) begin
      cv  = fast || (c >= 30) || ($urandom_range(3) != 0);
      okv = rom_rd && (phase == 1) && (c >= start_c + 1 + lat);
      cen    = cv;
      rom_ok = okv;
      if (phase == 0) begin
        eb[c] = cv && is_new && (rg != R_OPEN);
        if (cv) begin
          if (!is_new) begin
            phase = 2;
          end else begin
            start_c = c;
            if (zero_wait) begin
              model_apply(rg, b, we, dout, rom_val, io_val);
              comp  = c;
              phase = 2;
            end else begin
              phase = 1;
            end
          end
        end
      end else if (phase == 1) begin
        eb[c]  = 1'b1;
        erc[c] = rom_rd;
        eic[c] = (rg == R_IO);
        eiw[c] = (rg == R_IO) && (we != 2'b00) && (cnt == IO_WS);
        if (cv) begin
          if ((rg == R_RAM) || (rom_rd && okv && c >= start_c + 2) || (rg == R_IO && cnt == IO_WS)) begin
            model_apply(rg, b, we, dout, rom_val, io_val);
            comp  = c;
            phase = 2;
          end else begin
            cnt++;
          end
        end
      end else begin
        tail++;
      end
      @(negedge clk);
      ob[c]  = cpu.cpu_busy;
      orc[c] = rom_cs;
      oic[c] = io_cs;
      oiw[c] = |io_we;
      if (c == comp) iowe_at_comp = io_we;
      @(posedge clk);
      #1;
    end
    cen    = 1'b0;
    rom_ok = 1'b0;
    check({tag, ".done"}, 64'(phase == 2), 64'(1));
    check({tag, ".busy"}, ob, eb);
    check({tag, ".rom_cs"}, orc, erc);
    check({tag, ".io_cs"}, oic, eic);
    check({tag, ".io_we"}, oiw, eiw);
    check({tag, ".din"}, 64'(cpu.cpu_din), 64'(m_din));
    if (is_new && rom_rd)
      check({tag, ".rom_addr"}, 64'(rom_addr), 64'(b[22:1]));
    if (is_new && rg == R_IO) begin
      check({tag, ".io_addr"}, 64'(io_addr), 64'(b[7:1]));
      if (we != 2'b00) begin
        check({tag, ".io_dout"}, 64'(io_dout), 64'(dout));
        check({tag, ".io_we_val"}, 64'(iowe_at_comp), 64'(we));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] b, pb;
    logic [1:0]  w, pw;
    logic [15:0] init1;
    logic [23:0] open_tab [4];
    open_tab = '{24'h400000, 24'h000100, 24'h008000, 24'h7FFFFE};

    rst = 1'b1; cen = 1'b1; rom_ok = 1'b0; rom_data = 16'd0; io_din = 16'd0;
    cpu.cpu_addr = 23'h002000; cpu.cpu_we = 2'b00; cpu.cpu_dout = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 64'(cpu.cpu_busy), 64'(0));
    check("rst.din", 64'(cpu.cpu_din), 64'(0));
    check("rst.cs", 64'({rom_cs, io_cs, io_we}), 64'(0));
    check("rst.regs", 64'({rom_addr, io_addr, io_dout}), 64'(0));
    cen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      b = 24'h004000;
      b[3:1] = 3'(i);
      do_access(b, 2'b11, 16'($urandom), 0, 1'b0, "init");
    end
    init1 = m_ram[1];

    do_access(24'h004002, 2'b01, 16'hA55A, 0, 1'b1, "t1.wr");
    do_access(24'h004002, 2'b00, 16'h0000, 0, 1'b1, "t1.rd");
    check("t1.lo", 64'(cpu.cpu_din[7:0]), 64'(8'h5A));
    check("t1.hi_kept", 64'(cpu.cpu_din[15:8]), 64'(init1[15:8]));

    do_access(24'h800100, 2'b00, 16'h0000, 4, 1'b1, "t2");
    check("t2.rom_addr", 64'(rom_addr), 64'(22'h000080));

    do_access(24'h800200, 2'b00, 16'h0000, 0, 1'b1, "t3");

    do_access(24'h000010, 2'b11, 16'h1234, 0, 1'b1, "t4");
    check("t4.io_addr", 64'(io_addr), 64'(7'h08));

    do_access(24'h400000, 2'b00, 16'h0000, 0, 1'b1, "t5.rd");
    check("t5.din", 64'(cpu.cpu_din), 64'(16'hFFFF));
    do_access(24'h400000, 2'b00, 16'h0000, 0, 1'b1, "t5.hold");

    b = 24'h812340;
    cpu.cpu_addr = b[23:1]; cpu.cpu_we = 2'b00; cen = 1'b1; rom_ok = 1'b0;
    @(negedge clk);
    check("t6.start_busy", 64'(cpu.cpu_busy), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6.rom_cs", 64'(rom_cs), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("t6.rst_cs", 64'(rom_cs), 64'(0));
    check("t6.rst_busy", 64'(cpu.cpu_busy), 64'(0));
    rom_ok = 1'b1;
    @(posedge clk);
    #1;
    check("t6.late_ok", 64'(rom_cs), 64'(0));
    check("t6.din", 64'(cpu.cpu_din), 64'(0));
    rom_ok = 1'b0;
    m_last_valid = 1'b0;
    m_din = 16'd0;
    rst = 1'b0;
    do_access(b, 2'b00, 16'h0000, 2, 1'b1, "t6.again");
    pb = b; pw = 2'b00;

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(6) == 0) begin
        b = pb; w = pw;
      end else begin
        case ($urandom_range(3))
          0: begin
            b = 24'h004000;
            b[13] = 1'($urandom_range(1));
            b[3:1] = 3'($urandom_range(7));
          end
          1: b = {1'b1, 22'($urandom), 1'b0};
          2: b = {16'h0000, 7'($urandom), 1'b0};
          default: b = open_tab[$urandom_range(3)];
        endcase
        w = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
      end
      do_access(b, w, 16'($urandom), int'($urandom_range(5)), 1'b0, "rnd");
      pb = b; pw = w;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
